// File: rtl/force_buffer_arbiter.sv
// Round-robin drain controller for force_output_buffer FIFOs (showahead off, 1-cycle read).
// Define FORCE_ARB_BURST_EN to keep granting one buffer for up to BURST_LEN consecutive words.
module force_buffer_arbiter #(
    parameter int NUM_BUFFERS        = 4,
    parameter int ID_WIDTH           = 2,
    parameter int FORCE_BUFFER_WIDTH = 32,
    parameter int BURST_LEN          = 4
) (
    input  logic                                      clock,
    input  logic                                      rst,
    input  logic [NUM_BUFFERS-1:0]                    buf_empty,
    input  logic [NUM_BUFFERS*FORCE_BUFFER_WIDTH-1:0] buf_q,
    output logic [NUM_BUFFERS-1:0]                    buf_rdreq,
    input  logic                                      out_ready,
    output logic                                      out_valid,
    output logic [FORCE_BUFFER_WIDTH-1:0]             out_data,
    output logic [ID_WIDTH-1:0]                       out_id,
    output logic                                      idle
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_BUFFERS - 1);

    if (NUM_BUFFERS < 2 || ID_WIDTH != $clog2(NUM_BUFFERS) || BURST_LEN < 1) begin : g_bad_params
        $error("force_buffer_arbiter: inconsistent parameters");
    end

    logic [0:0]          state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] grant;
    logic [ID_WIDTH-1:0] sel;
    logic [ID_WIDTH-1:0] next_ptr;
    logic                can_issue;

    assign can_issue = (~&buf_empty) & ((state == ST_IDLE) | out_ready);

    // First non-empty buffer at or after rr_ptr, wrapping.
    always_comb begin
        logic found;
        int   idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_BUFFERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_BUFFERS) idx = idx - NUM_BUFFERS;
            if (!found && !buf_empty[idx]) begin
                grant = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
    end

`ifdef FORCE_ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

    logic [CNT_W-1:0] burst_cnt;
    logic             stay;

    // burst_cnt==0 only after reset: no previous grant to stay on.
    assign stay = (burst_cnt != '0) && (burst_cnt < CNT_MAX) && !buf_empty[out_id];
    assign sel  = stay ? out_id : grant;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (can_issue) begin
            burst_cnt <= stay ? burst_cnt + 1'b1 : CNT_W'(1);
        end
    end
`else
    assign sel = grant;
`endif

    assign next_ptr = (sel == LAST_ID) ? '0 : sel + 1'b1;

    always_comb begin
        buf_rdreq = '0;
        if (can_issue && !rst) buf_rdreq[sel] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            out_id <= '0;
            rr_ptr <= '0;
        end else if (can_issue) begin
            state  <= ST_HOLD;
            out_id <= sel;
            rr_ptr <= next_ptr;
        end else if (state == ST_HOLD && out_ready) begin
            state  <= ST_IDLE;
        end
    end

    // The popped word sits on the buffer's q; it is muxed out, not re-registered.
    assign out_valid = (state == ST_HOLD);
    assign out_data  = buf_q[int'(out_id)*FORCE_BUFFER_WIDTH +: FORCE_BUFFER_WIDTH];
    assign idle      = (state == ST_IDLE) & (&buf_empty);

endmodule

// File: tb/tb_force_buffer_arbiter.sv
// Bench for force_buffer_arbiter: scfifo models, grant table, corner sequences, random drains.
// Expectations follow FORCE_ARB_BURST_EN when the bench is built with that macro.
module tb_force_buffer_arbiter;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int W     = 32;
    localparam int BL    = 4;
    localparam int DEPTH = 64;
`ifdef FORCE_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           rst;
    logic [N-1:0]   buf_empty;
    logic [N*W-1:0] buf_q;
    logic [N-1:0]   buf_rdreq;
    logic           out_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           idle;

    always #5 clock = ~clock;

    force_buffer_arbiter #(
        .NUM_BUFFERS(N), .ID_WIDTH(IDW), .FORCE_BUFFER_WIDTH(W), .BURST_LEN(BL)
    ) dut (
        .clock(clock), .rst(rst), .buf_empty(buf_empty), .buf_q(buf_q),
        .buf_rdreq(buf_rdreq), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_id(out_id), .idle(idle)
    );

    // scfifo models: words written by the stimulus, popped on rdreq at the clock edge.
    logic [W-1:0] mem [N][DEPTH];
    int           wr_cnt [N];
    int           rd_cnt [N];
    logic [N-1:0] model_empty;
    logic [N-1:0] tbl_empty;
    bit           use_tbl;

    always_comb begin
        model_empty = '0;
        for (int i = 0; i < N; i++) model_empty[i] = (wr_cnt[i] == rd_cnt[i]);
    end
    assign buf_empty = use_tbl ? tbl_empty : model_empty;

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (buf_rdreq[i]) begin
                buf_q[i*W +: W] <= mem[i][rd_cnt[i] % DEPTH];
                rd_cnt[i]       <= rd_cnt[i] + 1;
            end
        end
    end

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } txn_t;

    typedef struct packed {
        logic [N-1:0] empty;
        logic         ready;
        logic [N-1:0] rdreq;
        logic         idle;
    } vec_t;

    txn_t acc  [$];
    txn_t expq [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [W-1:0] d);
        mem[i][wr_cnt[i] % DEPTH] = d;
        wr_cnt[i] = wr_cnt[i] + 1;
    endtask

    task automatic neg(input bit rdy);
        @(negedge clock);
        out_ready = rdy;
    endtask

    // Settle after input changes, check the per-cycle invariants, log accepted words.
    task automatic settle();
        #1;
        check("rdreq_onehot0", $onehot0(buf_rdreq), 1);
        check("rdreq_to_empty", |(buf_rdreq & buf_empty), 0);
        if (out_valid && out_ready) acc.push_back({out_id, out_data});
    endtask

    task automatic tick(input bit rdy);
        neg(rdy);
        settle();
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_id", out_id, 0);
        check("rst_rdreq", buf_rdreq, 0);
        @(negedge clock);
        rst = 1'b0;
        acc.delete();
    endtask

    task automatic drain();
        int guard = 0;
        tick(1'b1);
        while (!idle && guard < 100) begin
            tick(1'b1);
            guard++;
        end
        check("drain_idle", idle, 1);
    endtask

    // Reference order of words: pure scheduling rules applied to the preloaded buffer contents.
    function automatic void build_expected();
        logic [W-1:0] sq [N][$];
        int ptr = 0, last = -1, cnt = 0, left = 0, g;
        expq.delete();
        for (int i = 0; i < N; i++)
            for (int k = rd_cnt[i]; k < wr_cnt[i]; k++) begin
                sq[i].push_back(mem[i][k % DEPTH]);
                left++;
            end
        while (left > 0) begin
            g = -1;
            if (BURST && last >= 0 && cnt > 0 && cnt < BL && sq[last].size() > 0) begin
                g = last;
                cnt++;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && sq[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
                cnt = 1;
            end
            expq.push_back('{id: IDW'(g), data: sq[g].pop_front()});
            ptr  = (g + 1) % N;
            last = g;
            left--;
        end
    endfunction

    vec_t tbl [8];
    int   exp_ids [8];
    int   seen [N];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        use_tbl = 1'b0;
        tbl_empty = '1;
        #2;
        check("reset_valid", out_valid, 0);
        check("reset_id", out_id, 0);
        check("reset_idle", idle, 1);
        check("reset_rdreq", buf_rdreq, 0);
        @(negedge clock);
        rst = 1'b0;

        // Grant table from IDLE with rr_ptr=0; patterns removed before the next edge.
        tbl[0] = '{empty: 4'b1111, ready: 1'b0, rdreq: 4'b0000, idle: 1'b1};
        tbl[1] = '{empty: 4'b1110, ready: 1'b1, rdreq: 4'b0001, idle: 1'b0};
        tbl[2] = '{empty: 4'b1101, ready: 1'b0, rdreq: 4'b0010, idle: 1'b0};
        tbl[3] = '{empty: 4'b1011, ready: 1'b1, rdreq: 4'b0100, idle: 1'b0};
        tbl[4] = '{empty: 4'b0111, ready: 1'b0, rdreq: 4'b1000, idle: 1'b0};
        tbl[5] = '{empty: 4'b0000, ready: 1'b1, rdreq: 4'b0001, idle: 1'b0};
        tbl[6] = '{empty: 4'b1010, ready: 1'b0, rdreq: 4'b0001, idle: 1'b0};
        tbl[7] = '{empty: 4'b0101, ready: 1'b1, rdreq: 4'b0010, idle: 1'b0};
        for (int v = 0; v < 8; v++) begin
            @(negedge clock);
            use_tbl = 1'b1;
            tbl_empty = tbl[v].empty;
            out_ready = tbl[v].ready;
            #1;
            check($sformatf("tbl%0d_rdreq", v), buf_rdreq, tbl[v].rdreq);
            check($sformatf("tbl%0d_idle", v), idle, tbl[v].idle);
            check($sformatf("tbl%0d_valid", v), out_valid, 0);
            use_tbl = 1'b0;
            tbl_empty = '1;
        end

        // Only buffer 2 holds 3 words.
        neg(1'b1);
        for (int k = 0; k < 3; k++) load(2, 32'hA000_0000 + k);
        settle();
        check("a_rdreq0", buf_rdreq, 4'b0100);
        check("a_valid0", out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1);
            check($sformatf("a_valid%0d", k + 1), out_valid, 1);
            check($sformatf("a_id%0d", k + 1), out_id, 2);
            check($sformatf("a_data%0d", k + 1), out_data, 32'hA000_0000 + k);
            check($sformatf("a_rdreq%0d", k + 1), buf_rdreq, (k < 2) ? 4'b0100 : 4'b0000);
        end
        tick(1'b1);
        check("a_valid_end", out_valid, 0);
        check("a_idle_end", idle, 1);

        // rr_ptr is 3; only buffer 0 non-empty -> wrap to 0, pointer then 1.
        neg(1'b1);
        load(0, 32'hB000_0000);
        settle();
        check("wrap_rdreq", buf_rdreq, 4'b0001);
        tick(1'b1);
        check("wrap_id", out_id, 0);
        check("wrap_data", out_data, 32'hB000_0000);
        tick(1'b1);
        check("wrap_idle", idle, 1);
        neg(1'b1);
        load(0, 32'hB000_0001);
        load(2, 32'hB000_0002);
        settle();
        check("wrap_next_rdreq", buf_rdreq, BURST ? 4'b0001 : 4'b0100);
        drain();

        // Four buffers with two words each, ready held high.
        do_reset();
        neg(1'b1);
        for (int i = 0; i < N; i++) begin
            seen[i] = 0;
            for (int k = 0; k < 2; k++) load(i, 32'hC000_0000 | (i << 4) | k);
        end
        settle();
        if (BURST) exp_ids = '{0, 0, 1, 1, 2, 2, 3, 3};
        else       exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int j = 0; j < 8; j++) begin
            tick(1'b1);
            check($sformatf("b_valid%0d", j), out_valid, 1);
            check($sformatf("b_id%0d", j), out_id, exp_ids[j]);
            check($sformatf("b_data%0d", j), out_data,
                  32'hC000_0000 | (exp_ids[j] << 4) | seen[exp_ids[j]]);
            seen[exp_ids[j]]++;
        end
        tick(1'b1);
        check("b_idle", idle, 1);

        // Back-pressure for 5 cycles while holding a word.
        do_reset();
        neg(1'b1);
        load(1, 32'hD000_0000);
        load(1, 32'hD000_0001);
        settle();
        check("c_rdreq_first", buf_rdreq, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0);
            check($sformatf("c_stall_rdreq%0d", k), buf_rdreq, 0);
            check($sformatf("c_stall_valid%0d", k), out_valid, 1);
            check($sformatf("c_stall_id%0d", k), out_id, 1);
            check($sformatf("c_stall_data%0d", k), out_data, 32'hD000_0000);
        end
        tick(1'b1);
        check("c_resume_rdreq", buf_rdreq, 4'b0010);
        check("c_resume_data", out_data, 32'hD000_0000);
        tick(1'b1);
        check("c_second_data", out_data, 32'hD000_0001);
        check("c_second_id", out_id, 1);
        tick(1'b1);
        check("c_valid_end", out_valid, 0);

        // Reset pulsed while holding a word.
        do_reset();
        neg(1'b0);
        load(0, 32'hE000_0000);
        load(3, 32'hE000_0003);
        settle();
        check("d_rdreq_first", buf_rdreq, 4'b0001);
        tick(1'b0);
        check("d_hold_valid", out_valid, 1);
        check("d_hold_data", out_data, 32'hE000_0000);
        neg(1'b0);
        load(0, 32'hE000_0001);
        #1;
        rst = 1'b1;
        #1;
        check("d_rst_valid", out_valid, 0);
        check("d_rst_rdreq", buf_rdreq, 0);
        check("d_rst_idle", idle, 0);
        @(negedge clock);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("d_after_rdreq", buf_rdreq, 4'b0001);
        check("d_after_valid", out_valid, 0);
        tick(1'b1);
        check("d_after_id", out_id, 0);
        check("d_after_data", out_data, 32'hE000_0001);
        drain();

        // Random preloaded contents, random back-pressure, order checked against the model.
        for (int r = 0; r < 6; r++) begin
            int guard;
            int n;
            do_reset();
            neg(1'b0);
            for (int i = 0; i < N; i++) begin
                int cnt = $urandom_range(0, 6);
                for (int k = 0; k < cnt; k++) load(i, $urandom);
            end
            build_expected();
            settle();
            guard = 0;
            while (!(acc.size() >= expq.size() && idle) && guard < 400) begin
                tick($urandom_range(0, 3) != 0);
                guard++;
            end
            check($sformatf("r%0d_done", r), guard < 400, 1);
            check($sformatf("r%0d_count", r), acc.size(), expq.size());
            n = (acc.size() < expq.size()) ? acc.size() : expq.size();
            for (int j = 0; j < n; j++) begin
                check($sformatf("r%0d_id%0d", r, j), acc[j].id, expq[j].id);
                check($sformatf("r%0d_data%0d", r, j), acc[j].data, expq[j].data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
